countdown_timer: RTL

- Two-digit decimal countdown timer (00–99) for the board demo. It is the down-counting counterpart of the existing up-counter display path.
- The start value is loaded from switches. Counting down runs at a 1 Hz tick derived from the board clock.
- Tens and ones are shown on two 7-segment digits. A done LED lights when the count reaches 00.
- Digits are held internally as BCD, so no divide or modulo sits in the count path.

---
 rtl/countdown_timer_if.sv | 14 +
 rtl/countdown_timer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_if.sv
// Control and display bundle for countdown_timer: the board drives en/clr/load/load_val,
// the timer returns the two 7-segment digits and the done LED.
interface countdown_timer_if;
  logic       en;
  logic       clr;
  logic       load;
  logic [6:0] load_val;
  logic [6:0] seg0;
  logic [6:0] seg1;
  logic       led;

  modport master (output en, clr, load, load_val, input seg0, seg1, led);
  modport slave  (input en, clr, load, load_val, output seg0, seg1, led);
endinterface

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer (00..99) with prescaled tick, active-low 7-segment outputs
// and a done LED. Optional macro DONE_BLINK_EN blinks the "00" display while done.
module countdown_timer #(
  parameter int TICK_DIV = 12000000,
  parameter int MAX_VAL  = 99
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  bus
);
  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
`ifdef DONE_BLINK_EN
  localparam logic [PW-1:0] HALF_LAST = PW'(TICK_DIV / 2 - 1);
`endif
  localparam logic [6:0]    GLYPH_0   = 7'b1000000;
  localparam logic [6:0]    BLANK     = 7'b1111111;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          led_q, led_d;
  logic [6:0]    seg0_q, seg0_d;
  logic [6:0]    seg1_q, seg1_d;
`ifdef DONE_BLINK_EN
  logic          blink_q, blink_d;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = BLANK;
    endcase
    return g;
  endfunction

  // Binary-to-BCD split only happens on the load path; counting stays in BCD.
  logic [6:0] sat_val;
  logic [3:0] tens_ld, ones_ld;
  assign sat_val = (bus.load_val > 7'(MAX_VAL)) ? 7'(MAX_VAL) : bus.load_val;
  assign tens_ld = 4'(sat_val / 7'd10);
  assign ones_ld = 4'(sat_val % 7'd10);

  logic value_zero, value_one, tick;
  assign value_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign value_one  = (tens_q == 4'd0) && (ones_q == 4'd1);
  assign tick       = (presc_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    led_d   = led_q;
`ifdef DONE_BLINK_EN
    blink_d = blink_q;
`endif
    if (bus.clr) begin
      state_d = IDLE;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      presc_d = '0;
      led_d   = 1'b0;
`ifdef DONE_BLINK_EN
      blink_d = 1'b0;
`endif
    end else if (bus.load) begin
      state_d = IDLE;
      tens_d  = tens_ld;
      ones_d  = ones_ld;
      presc_d = '0;
      led_d   = 1'b0;
`ifdef DONE_BLINK_EN
      blink_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
          if (bus.en && !value_zero) state_d = RUN;
        end
        RUN: begin
          if (!bus.en) begin
            state_d = PAUSE;
          end else if (tick) begin
            presc_d = '0;
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end
            if (value_one) begin
              state_d = DONE;
              led_d   = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSE: begin
          if (bus.en) state_d = RUN;
        end
        DONE: begin
          led_d = 1'b1;
`ifdef DONE_BLINK_EN
          // Prescaler is reused as the half-period blink counter.
          if (presc_q == HALF_LAST) begin
            presc_d = '0;
            blink_d = ~blink_q;
          end else begin
            presc_d = presc_q + 1'b1;
          end
`else
          presc_d = '0;
`endif
        end
        default: state_d = IDLE;
      endcase
    end

    seg0_d = glyph(tens_q);
    seg1_d = glyph(ones_q);
`ifdef DONE_BLINK_EN
    if (blink_q) begin
      seg0_d = BLANK;
      seg1_d = BLANK;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      presc_q <= '0;
      led_q   <= 1'b0;
      seg0_q  <= GLYPH_0;
      seg1_q  <= GLYPH_0;
`ifdef DONE_BLINK_EN
      blink_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
      led_q   <= led_d;
      seg0_q  <= seg0_d;
      seg1_q  <= seg1_d;
`ifdef DONE_BLINK_EN
      blink_q <= blink_d;
`endif
    end
  end

  assign bus.seg0 = seg0_q;
  assign bus.seg1 = seg1_q;
  assign bus.led  = led_q;

endmodule
